// File: rtl/usb_buff_pkg.sv
// Shared types and defaults for the USB 3.1 packet-buffer arbiter.
// The FSM state type and the requester-index width helper live here so every user agrees on them.
package usb_buff_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_ADDR_W  = 10;
  localparam int DEF_LEN_W   = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    GAP   = 2'd2
  } buff_arb_state_e;

  // Width of a requester index; never narrower than one bit.
  function automatic int req_idx_w(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  localparam int REQ_IDX_W = req_idx_w(DEF_NUM_REQ);

endpackage

// File: rtl/usb_buff_rr_pick.sv
// Combinational round-robin picker: lowest set request at or after ptr_i wins.
// The request vector is doubled, shifted down by the pointer and priority-encoded.
module usb_buff_rr_pick
  import usb_buff_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [req_idx_w(NUM_REQ)-1:0] ptr_i,
  output logic [req_idx_w(NUM_REQ)-1:0] win_o,
  output logic                          vld_o
);

  localparam int IDX_W = req_idx_w(NUM_REQ);

  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  int                   sum;

  always_comb begin
    // NOTE: every output and temporary gets a default first, so no path leaves one unassigned and no latch is inferred.
    dbl   = {req_i, req_i} >> ptr_i;
    rot   = dbl[NUM_REQ-1:0];
    win_o = '0;
    vld_o = 1'b0;
    sum   = 0;
    // Walk downwards so the lowest rotated position (closest to ptr_i) is written last.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        sum = i + int'(ptr_i);
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        win_o = IDX_W'(sum);
        vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/usb_buff_arbiter.sv
// Round-robin arbiter and burst sequencer for the shared USB 3.1 packet buffer.
// One requester owns the buffer per burst; each accepted beat strobes the buffer at a wrapping address.
module usb_buff_arbiter
  import usb_buff_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int LEN_W   = DEF_LEN_W
) (
  input  logic                      ext_clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ-1:0]        req_we_i,
  input  logic [NUM_REQ*LEN_W-1:0]  req_len_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ-1:0]        beat_vld_i,
  input  logic                      buf_rdy_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  output logic [NUM_REQ-1:0]        beat_ack_o,
  output logic                      buf_en_o,
  output logic                      buf_we_o,
  output logic [ADDR_W-1:0]         buf_addr_o,
  output logic [NUM_REQ-1:0]        done_o,
  output logic [NUM_REQ-1:0]        abort_o,
  output logic                      busy_o
);

  localparam int IDX_W = req_idx_w(NUM_REQ);

  buff_arb_state_e     state_q, state_d;
  logic [IDX_W-1:0]    win_q, win_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [NUM_REQ-1:0]  done_q, done_d;
  logic [NUM_REQ-1:0]  abort_q, abort_d;

  logic [IDX_W-1:0]    pick_win;
  logic                pick_vld;
  logic [LEN_W-1:0]    pick_len;
  logic [ADDR_W-1:0]   pick_addr;

  logic                in_burst;
  logic                cnt_zero;
  logic                accept;
  logic                last_beat;
  logic                abort_now;

  usb_buff_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req_i (req_i),
    .ptr_i (rr_ptr_q),
    .win_o (pick_win),
    .vld_o (pick_vld)
  );

  assign pick_len  = req_len_i[int'(pick_win)*LEN_W +: LEN_W];
  assign pick_addr = req_addr_i[int'(pick_win)*ADDR_W +: ADDR_W];

  // A dropped request still lets the final beat through, so that case ends as done rather than abort.
  assign in_burst  = (state_q == BURST);
  assign cnt_zero  = (cnt_q == '0);
  assign accept    = in_burst & beat_vld_i[win_q] & buf_rdy_i & (req_i[win_q] | cnt_zero);
  assign last_beat = accept & cnt_zero;
  assign abort_now = in_burst & ~req_i[win_q] & ~accept;

  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    rr_ptr_d = rr_ptr_q;
    we_d     = we_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    gnt_d    = gnt_q;
    done_d   = '0;
    abort_d  = '0;

    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = BURST;
          win_d   = pick_win;
          we_d    = req_we_i[pick_win];
          addr_d  = pick_addr;
          cnt_d   = pick_len;
          gnt_d   = NUM_REQ'(1) << pick_win;
        end
      end

      BURST: begin
        if (accept) begin
          addr_d = addr_q + 1'b1;
          cnt_d  = cnt_q - 1'b1;
        end
        if (last_beat) begin
          state_d       = GAP;
          gnt_d         = '0;
          done_d[win_q] = 1'b1;
        end else if (abort_now) begin
          state_d        = GAP;
          gnt_d          = '0;
          abort_d[win_q] = 1'b1;
        end
      end

      GAP: begin
        // The requester just served drops to lowest priority for the next arbitration.
        state_d  = IDLE;
        rr_ptr_d = (win_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
      end

      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge ext_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      win_q    <= '0;
      rr_ptr_q <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      cnt_q    <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      abort_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments make every register update from the same pre-edge values.
      state_q  <= state_d;
      win_q    <= win_d;
      rr_ptr_q <= rr_ptr_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      abort_q  <= abort_d;
    end
  end

  assign gnt_o      = gnt_q;
  assign beat_ack_o = gnt_q & {NUM_REQ{accept}};
  assign buf_en_o   = accept;
  assign buf_we_o   = we_q & accept;
  assign buf_addr_o = addr_q;
  assign done_o     = done_q;
  assign abort_o    = abort_q;
  assign busy_o     = (state_q != IDLE);

endmodule

// File: doc/usb_buff_arbiter.md
# usb_buff_arbiter

Round-robin arbiter and sequencer for the shared USB 3.1 packet buffer. It takes burst requests from up to `NUM_REQ` endpoint/DMA requesters, grants one at a time, and holds the grant for the whole burst. For each accepted beat it drives the buffer's enable, write-enable and wrapping address, and it reports per-requester beat acknowledge, burst completion and abort. It sits between the endpoint engines and the buffer memory, which the buffer master agent drives in verification.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8.
- `ADDR_W`, 10: buffer address width. Addresses wrap modulo 2^ADDR_W.
- `LEN_W`, 8: burst-length field width. A field value L means L+1 beats.

Ports:
- `ext_clk`  in  1  single block clock, all logic rising-edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_i`  in  NUM_REQ  per-requester burst request, level. Must stay high until `done_o`/`abort_o`.
- `req_we_i`  in  NUM_REQ  per-requester direction: 1 = write, 0 = read.
- `req_len_i`  in  NUM_REQ*LEN_W  per-requester beats-minus-one, packed, requester 0 in LSBs.
- `req_addr_i`  in  NUM_REQ*ADDR_W  per-requester start address, packed.
- `beat_vld_i`  in  NUM_REQ  requester has a beat ready.
- `buf_rdy_i`  in  1  buffer can accept a beat this cycle.
- `gnt_o`  out  NUM_REQ  one-hot grant, registered.
- `beat_ack_o`  out  NUM_REQ  beat accepted this cycle.
- `buf_en_o`  out  1  buffer access strobe.
- `buf_we_o`  out  1  buffer write-enable.
- `buf_addr_o`  out  ADDR_W  buffer address.
- `done_o`  out  NUM_REQ  one-cycle pulse when a burst completes.
- `abort_o`  out  NUM_REQ  one-cycle pulse when a burst is aborted.
- `busy_o`  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, BURST, GAP.
- **IDLE:** if any `req_i` is high, pick a winner round-robin starting at `rr_ptr`. On the same edge latch the winner index, `req_we_i`, `req_addr_i` into `addr_q`, and `req_len_i` into `cnt_q`. Then go to BURST. If no request is high, stay in IDLE.
- **BURST:**
  - `gnt_o` is one-hot on the winner.
  - accept = `beat_vld_i[win]` & `buf_rdy_i`.
  - `buf_en_o`, `buf_we_o` and `beat_ack_o[win]` are combinational from accept. `buf_we_o` = latched direction & accept. `buf_addr_o` = `addr_q`.
  - On each accept: `addr_q` ← `addr_q`+1, modulo 2^ADDR_W, and `cnt_q` decrements.
  - An accept with `cnt_q`==0 is the last beat: go to GAP and set the done flag.
- **Abort:** if `req_i[win]` falls while in BURST (and that cycle is not the last accept), go to GAP and set the abort flag. No beat is accepted in the abort cycle.
- **GAP:** lasts exactly one cycle.
  - `gnt_o` is 0.
  - `done_o[win]` or `abort_o[win]` is high; these are registered pulses.
  - `rr_ptr` ← win+1, modulo NUM_REQ.
  - Next state is IDLE.
- **Round-robin:** the requester just served has lowest priority in the next arbitration. Requests that are not granted are never dropped.
- **Unused requesters:** inputs with index ≥ NUM_REQ do not exist. `req_i` bits must be gated by the instantiating logic.

## Timing
- **Reset (async assert, sync deassert handled upstream):** state IDLE, `rr_ptr` 0. All outputs 0: `gnt_o`, `beat_ack_o`, `buf_en_o`, `buf_we_o`, `buf_addr_o`, `done_o`, `abort_o`, `busy_o`.
- **Reset mid-burst:** the burst is abandoned with no `done_o` or `abort_o`. Buffer contents are not the arbiter's concern.
- **Request to grant:** `req_i` sampled high at edge T (in IDLE) gives `gnt_o` high from T+1. The first beat can be accepted in cycle T+1.
- **Burst length:** a burst of L+1 beats with no stalls occupies L+1 BURST cycles. Each `buf_rdy_i`=0 or `beat_vld_i`=0 cycle adds one cycle, with address and count held.
- **Turnaround:** last accept in cycle T. GAP is cycle T+1 (done pulse). IDLE is T+2. The next grant is at T+3. Minimum spacing is 2 dead cycles between bursts.
- **Zero-length field:** L=0 gives exactly 1 beat.
- **Simultaneous requests:** only one grant at a time. Order is rr_ptr, rr_ptr+1, …
- **Concurrent events:** the last accept and `req_i` falling in the same cycle count as done, not abort.

## Structure
- Shared package `usb_buff_pkg`:
  - FSM state enum `buff_arb_state_e` (IDLE, BURST, GAP).
  - Default `NUM_REQ`, `ADDR_W`, `LEN_W` localparams.
  - Index-width function `clog2`-based `REQ_IDX_W`.
- One sub-module, `usb_buff_rr_pick`: purely combinational. Inputs are request vector and pointer; outputs are winner index and valid. Uses the double-width rotate-and-priority-encode method.
- The top module holds the FSM, latched burst context, `addr_q`/`cnt_q` counters and `rr_ptr`.

## Test plan
- **Single burst:** req0 with len=3, addr=0x010, we=1; `beat_vld_i`=1, `buf_rdy_i`=1. Expect `gnt_o`=0001 from T+1; four accepts at addresses 0x010–0x013 with `buf_we_o`=1; `done_o[0]` pulse in GAP; `busy_o` low at T+6.
- **All four requesting:** len=0 each. Expect grants in order 0,1,2,3, each one beat, each followed by GAP/IDLE. A re-assertion of req0 is granted after 3.
- **Stall:** len=7, `buf_rdy_i` low for 3 cycles after beat 2. Expect `buf_addr_o` and the count to hold, no `beat_ack_o` during the stall, and 8 beats total in 11 BURST cycles.
- **Wrap:** ADDR_W=10, addr 0x3FE, len=3. Expect addresses 0x3FE, 0x3FF, 0x000, 0x001.
- **Abort:** req2 deasserted after 2 of 5 beats. Expect `abort_o[2]` pulse, no `done_o[2]`, and a pending req3 granted at abort+3.
- **Reset mid-burst:** assert `reset_n` low during beat 4. Expect all outputs 0 immediately; after release, req1 and req0 arbitrate starting at requester 0.
